cdc_sync_filt: RTL

Parametrised multi-bit input synchroniser with configurable chain depth, an optional per-bit glitch filter and registered edge detection. Each bit of an asynchronous input bus passes through a STAGES-deep flop chain into the `clk` domain. An optional stability filter requires a new value to persist for FILTER consecutive cycles before `q` follows it. Per-bit single-cycle rise/fall pulses are produced from `q`. It replaces the fixed two-flop synchroniser wherever buttons, external status lines or slow cross-domain flags need cleaning and edge events.

---
 rtl/cdc_sync_filt_pkg.sv | 16 +
 rtl/cdc_sync_filt_glitch_filter.sv | 43 ++++
 rtl/cdc_sync_filt.sv | 85 ++++++++
 3 files changed

// File: rtl/cdc_sync_filt_pkg.sv
// Purpose: shared constants and helpers for the cdc_sync_filt synchroniser.
//   MIN_STAGES       - smallest legal synchroniser chain depth.
//   filt_cnt_width() - bit width needed for a stability counter that has
//                      to reach FILTER-1 (never narrower than one bit).
package cdc_sync_filt_pkg;

    localparam int MIN_STAGES = 2;

    function automatic int filt_cnt_width(input int filter);
        if (filter < 1) begin
            return 1;
        end
        return $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/cdc_sync_filt_glitch_filter.sv
// Purpose: single-bit stability filter. The output only follows the input
// once the input has disagreed with it for FILTER consecutive cycles.
// Any shorter excursion is discarded and the counter restarts from zero.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   in    in  1  synchronised input bit
//   out   out 1  filtered bit (RST_BIT after reset)
module cdc_glitch_filter
    import cdc_sync_filt_pkg::*;
#(
    parameter int   FILTER  = 1,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int CNT_W = filt_cnt_width(FILTER);

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= RST_BIT;
        end else if (in == r_out) begin
            // Agreement at any point cancels a partly counted change.
            r_cnt <= '0;
        end else if (int'(r_cnt) == FILTER - 1) begin
            r_out <= in;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out = r_out;

endmodule

// File: rtl/cdc_sync_filt.sv
// Purpose: multi-bit asynchronous input synchroniser with an optional
// per-bit stability filter and registered rise/fall edge detection.
// Ports:
//   clk      in  1      destination clock, rising edge
//   rst_n    in  1      asynchronous active-low reset
//   d        in  WIDTH  asynchronous input bus, bits independent
//   q        out WIDTH  synchronised (and optionally filtered) value
//   rise     out WIDTH  one-cycle pulse when q[i] goes 0->1
//   fall     out WIDTH  one-cycle pulse when q[i] goes 1->0
//   any_edge out 1      OR of all rise and fall bits
module cdc_sync_filt
    import cdc_sync_filt_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 2,
    parameter int               FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("cdc_sync_filt: STAGES must be at least 2");
    end

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_q_d;
    logic [WIDTH-1:0] w_s_out;
    logic [WIDTH-1:0] w_q;

    // Pure flop chain: nothing may sit between stages, so the first flop
    // is the only one that can go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s_out = r_sync[STAGES-1];

    if (FILTER == 0) begin : g_no_filter
        assign w_q = w_s_out;
    end else begin : g_filter
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            cdc_glitch_filter #(
                .FILTER  (FILTER),
                .RST_BIT (RESET_VAL[i])
            ) u_filt (
                .clk   (clk),
                .rst_n (rst_n),
                .in    (w_s_out[i]),
                .out   (w_q[i])
            );
        end
    end

    // History resets to the same value as q so releasing reset never
    // looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_d <= RESET_VAL;
        end else begin
            r_q_d <= w_q;
        end
    end

    assign q        = w_q;
    assign rise     = w_q & ~r_q_d;
    assign fall     = ~w_q & r_q_d;
    assign any_edge = |(rise | fall);

endmodule
